// File: rtl/cp0_intc.sv
// CP0 interrupt/exception controller: synchronised HW lines with level or sticky-edge capture,
// Count/Compare timer on line N_HWINT, priority-encoded interrupt ID and EXL-protected EPC.
module cp0_intc #(
    parameter int          N_HWINT     = 6,
    parameter logic [6:0]  EDGE_MASK   = 7'b0000000,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] PRID        = 32'hbbaaccff
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_HWINT-1:0] hwint,
    input  logic [29:0]        pc_next,
    input  logic               exl_set,
    input  logic               exl_clr,
    input  logic               cp0_wen,
    input  logic [4:0]         cp0_sel,
    input  logic [31:0]        cp0_din,
    output logic [31:0]        cp0_dout,
    output logic [29:0]        epc,
    output logic               int_req,
    output logic [2:0]         int_id
);
    localparam int                 L          = N_HWINT + 1;
    localparam logic [8:0]         IMPL_W     = (9'd1 << L) - 9'd1;
    localparam logic [7:0]         IMPL       = IMPL_W[7:0];
    localparam logic [N_HWINT-1:0] EDGE_LINES = EDGE_MASK[N_HWINT-1:0];

    logic [N_HWINT-1:0] s_s;
    logic [N_HWINT-1:0] prev_q, prev_d, pend_q, pend_d, w1c_s;
    logic [7:0]         im_q, im_d, ip_s, hit_s;
    logic               ie_q, ie_d, exl_q, exl_d, tpend_q, tpend_d;
    logic [29:0]        epc_q, epc_d;
    logic [4:0]         cid_q, cid_d;
    logic [31:0]        count_q, count_d, compare_q, compare_d;
    logic               wr_count_s, wr_compare_s, wr_sr_s, wr_cause_s, wr_epc_s;
    logic [2:0]         id_s;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign s_s = hwint;
        end else begin : g_sync
            logic [N_HWINT-1:0] sync_q [SYNC_STAGES];
            logic [N_HWINT-1:0] sync_d [SYNC_STAGES];

            // Shift chain feeding each stage from the previous one.
            always_comb begin
                sync_d[0] = hwint;
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    sync_d[k] = sync_q[k-1];
                end
            end

            // Synchroniser flops.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= '0;
                    end
                end else begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_d[k];
                    end
                end
            end
            assign s_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    assign wr_count_s   = cp0_wen && (cp0_sel == 5'd9);
    assign wr_compare_s = cp0_wen && (cp0_sel == 5'd11);
    assign wr_sr_s      = cp0_wen && (cp0_sel == 5'd12);
    assign wr_cause_s   = cp0_wen && (cp0_sel == 5'd13);
    assign wr_epc_s     = cp0_wen && (cp0_sel == 5'd14);

    // Pending lines, enabled hits and the highest-index hit.
    always_comb begin
        ip_s = 8'd0;
        for (int i = 0; i < N_HWINT; i++) begin
            ip_s[i] = EDGE_LINES[i] ? pend_q[i] : s_s[i];
        end
        ip_s[N_HWINT] = tpend_q;
        hit_s = ip_s & im_q;
        id_s  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            id_s = hit_s[i] ? 3'(i) : id_s;
        end
    end

    assign int_id  = id_s;
    assign int_req = (|hit_s) & ie_q & ~exl_q;
    assign epc     = epc_q;

    // Edge capture (set wins over W1C) and Count/Compare timer.
    always_comb begin
        w1c_s     = wr_cause_s ? cp0_din[8 +: N_HWINT] : '0;
        prev_d    = s_s;
        pend_d    = (pend_q & ~w1c_s) | (s_s & ~prev_q & EDGE_LINES);
        count_d   = wr_count_s ? cp0_din : count_q + 32'd1;
        compare_d = wr_compare_s ? cp0_din : compare_q;
        if (wr_compare_s) begin
            tpend_d = 1'b0;
        end else if (count_q == compare_q) begin
            tpend_d = 1'b1;
        end else begin
            tpend_d = tpend_q;
        end
    end

    // Status and exception state; a taken exception outranks eret, which outranks mtc0.
    always_comb begin
        im_d  = im_q;
        ie_d  = ie_q;
        exl_d = exl_q;
        epc_d = epc_q;
        cid_d = cid_q;
        if (wr_sr_s) begin
            im_d = cp0_din[15:8] & IMPL;
            ie_d = cp0_din[0];
        end else begin
            im_d = im_q;
        end
        if (exl_set) begin
            exl_d = 1'b1;
            if (!exl_q) begin
                epc_d = pc_next;
                cid_d = {2'b00, id_s};
            end else begin
                epc_d = epc_q;
            end
        end else if (exl_clr) begin
            exl_d = 1'b0;
        end else begin
            exl_d = wr_sr_s ? cp0_din[1] : exl_q;
            epc_d = wr_epc_s ? cp0_din[31:2] : epc_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q    <= '0;
            pend_q    <= '0;
            im_q      <= 8'd0;
            ie_q      <= 1'b0;
            exl_q     <= 1'b0;
            tpend_q   <= 1'b0;
            epc_q     <= 30'd0;
            cid_q     <= 5'd0;
            count_q   <= 32'd0;
            compare_q <= 32'hFFFFFFFF;
        end else begin
            prev_q    <= prev_d;
            pend_q    <= pend_d;
            im_q      <= im_d;
            ie_q      <= ie_d;
            exl_q     <= exl_d;
            tpend_q   <= tpend_d;
            epc_q     <= epc_d;
            cid_q     <= cid_d;
            count_q   <= count_d;
            compare_q <= compare_d;
        end
    end

    // mfc0 read mux; reflects register state before any same-cycle write.
    always_comb begin
        case (cp0_sel)
            5'd9:    cp0_dout = count_q;
            5'd11:   cp0_dout = compare_q;
            5'd12:   cp0_dout = {16'd0, im_q, 6'd0, exl_q, ie_q};
            5'd13:   cp0_dout = {11'd0, cid_q, ip_s, 8'd0};
            5'd14:   cp0_dout = {epc_q, 2'b00};
            5'd15:   cp0_dout = PRID;
            default: cp0_dout = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_cp0_intc.sv
// Directed bench for cp0_intc: 6 HW lines, line 0 edge-latched, 2 sync stages, timer on line 6.
module tb_cp0_intc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  hwint = 6'd0;
    logic [29:0] pc_next = 30'd0;
    logic        exl_set = 1'b0, exl_clr = 1'b0, cp0_wen = 1'b0;
    logic [4:0]  cp0_sel = 5'd0;
    logic [31:0] cp0_din = 32'd0;
    logic [31:0] cp0_dout;
    logic [29:0] epc;
    logic        int_req;
    logic [2:0]  int_id;
    int          checks = 0;
    int          failures = 0;

    cp0_intc #(.N_HWINT(6), .EDGE_MASK(7'b0000001), .SYNC_STAGES(2), .PRID(32'hbbaaccff)) dut (
        .clk(clk), .rst(rst), .hwint(hwint), .pc_next(pc_next), .exl_set(exl_set),
        .exl_clr(exl_clr), .cp0_wen(cp0_wen), .cp0_sel(cp0_sel), .cp0_din(cp0_din),
        .cp0_dout(cp0_dout), .epc(epc), .int_req(int_req), .int_id(int_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [4:0] sel, input logic [31:0] din);
        cp0_wen = 1'b1;
        cp0_sel = sel;
        cp0_din = din;
        tick(1);
        cp0_wen = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [4:0] sel, input logic [31:0] exp);
        cp0_sel = sel;
        #1;
        check(tag, cp0_dout, exp);
    endtask

    initial begin
        // Reset state
        #1 rst = 1'b0;
        #2;
        check("rst_int_req", {31'd0, int_req}, 32'd0);
        check("rst_int_id", {29'd0, int_id}, 32'd0);
        rd("rst_prid", 5'd15, 32'hbbaaccff);
        rd("rst_compare", 5'd11, 32'hFFFFFFFF);
        rd("rst_sr", 5'd12, 32'd0);
        tick(2);
        rst = 1'b1;
        tick(3);
        rd("count_incr", 5'd9, 32'd3);
        rd("unmapped", 5'd3, 32'd0);
        wr(5'd15, 32'h12345678);
        rd("prid_ro", 5'd15, 32'hbbaaccff);

        // Level line 2
        wr(5'd12, 32'h0000_0401);
        hwint[2] = 1'b1;
        tick(1);
        check("lvl_lat1", {31'd0, int_req}, 32'd0);
        tick(1);
        check("lvl_req", {31'd0, int_req}, 32'd1);
        check("lvl_id", {29'd0, int_id}, 32'd2);
        rd("lvl_cause", 5'd13, 32'h0000_0400);
        hwint[2] = 1'b0;
        tick(2);
        check("lvl_clr_req", {31'd0, int_req}, 32'd0);
        rd("lvl_clr_cause", 5'd13, 32'd0);

        // Edge line 0: sticky, W1C, set wins over clear
        hwint[0] = 1'b1;
        tick(1);
        hwint[0] = 1'b0;
        tick(1);
        rd("edge_lat", 5'd13, 32'd0);
        tick(4);
        rd("edge_sticky", 5'd13, 32'h0000_0100);
        wr(5'd13, 32'h0000_0100);
        rd("edge_w1c", 5'd13, 32'd0);
        hwint[0] = 1'b1;
        tick(1);
        hwint[0] = 1'b0;
        tick(1);
        wr(5'd13, 32'h0000_0100);
        rd("edge_set_wins", 5'd13, 32'h0000_0100);

        // Timer on line 6
        wr(5'd12, 32'h0000_4001);
        wr(5'd11, 32'd5);
        wr(5'd9, 32'd0);
        tick(5);
        rd("tmr_count5", 5'd9, 32'd5);
        check("tmr_not_yet", {31'd0, int_req}, 32'd0);
        tick(1);
        check("tmr_req", {31'd0, int_req}, 32'd1);
        check("tmr_id", {29'd0, int_id}, 32'd6);
        rd("tmr_cause", 5'd13, 32'h0000_4100);
        wr(5'd11, 32'h0000_0100);
        check("tmr_clr", {31'd0, int_req}, 32'd0);

        // Nesting: EPC and CID preserved on a second exl_set
        wr(5'd12, 32'h0000_0A01);
        hwint[1] = 1'b1;
        hwint[3] = 1'b1;
        tick(2);
        check("nest_id", {29'd0, int_id}, 32'd3);
        check("nest_req", {31'd0, int_req}, 32'd1);
        pc_next = 30'h100;
        exl_set = 1'b1;
        tick(1);
        exl_set = 1'b0;
        rd("nest_epc", 5'd14, 32'h0000_0400);
        check("nest_epc_out", {2'b00, epc}, 32'h0000_0100);
        rd("nest_cause", 5'd13, 32'h0003_0B00);
        rd("nest_sr", 5'd12, 32'h0000_0A03);
        check("nest_exl_mask", {31'd0, int_req}, 32'd0);
        hwint[3] = 1'b0;
        tick(2);
        pc_next = 30'h200;
        exl_set = 1'b1;
        tick(1);
        exl_set = 1'b0;
        rd("nest2_epc", 5'd14, 32'h0000_0400);
        rd("nest2_cause", 5'd13, 32'h0003_0300);
        exl_clr = 1'b1;
        tick(1);
        exl_clr = 1'b0;
        rd("eret_sr", 5'd12, 32'h0000_0A01);

        // Collision: exl_set with mtc0 SR in the same cycle
        pc_next = 30'h55;
        exl_set = 1'b1;
        cp0_wen = 1'b1;
        cp0_sel = 5'd12;
        cp0_din = 32'h0000_FF00;
        #1;
        check("rdw_pre", cp0_dout, 32'h0000_0A01);
        tick(1);
        exl_set = 1'b0;
        cp0_wen = 1'b0;
        rd("coll_sr", 5'd12, 32'h0000_7F02);
        rd("coll_epc", 5'd14, 32'h0000_0154);
        exl_clr = 1'b1;
        tick(1);
        exl_clr = 1'b0;
        rd("coll_clr_sr", 5'd12, 32'h0000_7F00);
        check("coll_id", {29'd0, int_id}, 32'd1);
        check("coll_req", {31'd0, int_req}, 32'd0);

        // Asynchronous reset mid-operation
        #2 rst = 1'b0;
        #1;
        rd("mid_rst_sr", 5'd12, 32'd0);
        rd("mid_rst_cause", 5'd13, 32'd0);
        rd("mid_rst_epc", 5'd14, 32'd0);
        rd("mid_rst_count", 5'd9, 32'd0);
        rd("mid_rst_compare", 5'd11, 32'hFFFFFFFF);
        check("mid_rst_id", {29'd0, int_id}, 32'd0);
        check("mid_rst_req", {31'd0, int_req}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
